// File: rtl/branch_cond_unit.sv
// Branch condition unit: owns the architectural ALU flags, tracks outstanding flag writers,
// holds a conditional branch until its flags are current and returns a registered resolution.
module branch_cond_unit #(
    parameter int PEND_W = 3,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              fw_alloc,
    output logic              fw_alloc_rdy,
    input  logic              fw_valid,
    input  logic [3:0]        fw_flags,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [2:0]        br_cond,
    input  logic              br_pred_taken,
    input  logic [31:0]       br_target,
    input  logic [31:0]       br_fallthru,
    input  logic [TAG_W-1:0]  br_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic              res_mispredict,
    output logic [31:0]       res_pc,
    output logic [TAG_W-1:0]  res_tag,
    output logic [1:0]        dbg_state,
    output logic [PEND_W-1:0] dbg_pend
);

    // Handshakes: a transfer happens on a cycle where valid && ready are both high at the
    // rising edge; valid may not depend on ready, and the offered payload is sampled only then.

    typedef struct packed {
        logic v;
        logic c;
        logic s;
        logic z;
    } flags_t;

    typedef struct packed {
        logic [2:0]       cond;
        logic             pred;
        logic [31:0]      target;
        logic [31:0]      fallthru;
        logic [TAG_W-1:0] tag;
    } branch_t;

    typedef struct packed {
        logic             taken;
        logic             mispredict;
        logic [31:0]      pc;
        logic [TAG_W-1:0] tag;
    } result_t;

    // dbg_state encoding: 0 idle, 1 waiting for flags, 2 result presented
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;

    state_t            state_q, state_d;
    flags_t            flags_q, flags_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    branch_t           hold_q, hold_d;
    result_t           res_q, res_d;

    branch_t in_br;
    flags_t  eval_flags;
    logic    bypass;
    logic    avail;
    logic    accept;
    logic    in_no_wait;
    logic    hold_no_wait;

    function automatic logic cond_true(input logic [2:0] cond, input flags_t f);
        logic t;
        t = 1'b0;
        case (cond)
            3'd0:    t = f.z;
            3'd1:    t = !f.z;
            3'd2:    t = f.s ^ f.v;
            3'd3:    t = !(f.s ^ f.v);
            3'd4:    t = f.c;
            3'd5:    t = !f.c;
            3'd6:    t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic result_t resolve(input branch_t b, input flags_t f);
        result_t r;
        r.taken      = cond_true(b.cond, f);
        r.mispredict = r.taken != b.pred;
        r.pc         = r.taken ? b.target : b.fallthru;
        r.tag        = b.tag;
        return r;
    endfunction

    always_comb begin
        in_br.cond     = br_cond;
        in_br.pred     = br_pred_taken;
        in_br.target   = br_target;
        in_br.fallthru = br_fallthru;
        in_br.tag      = br_tag;

        // The last outstanding writer retiring this cycle makes its flags usable right away.
        bypass       = (pend_q == PEND_ONE) && fw_valid && !fw_alloc;
        avail        = (pend_q == PEND_ZERO) || bypass;
        eval_flags   = bypass ? flags_t'(fw_flags) : flags_q;
        in_no_wait   = avail || (br_cond[2:1] == 2'b11);
        hold_no_wait = avail || (hold_q.cond[2:1] == 2'b11);

        fw_alloc_rdy = pend_q != PEND_MAX;
        br_ready     = !rst && !flush &&
                       ((state_q == IDLE) || ((state_q == RESP) && res_ready));
        accept       = br_valid && br_ready;

        pend_d = pend_q;
        if (flush) begin
            pend_d = PEND_ZERO;
        end else if (fw_alloc && !fw_valid && (pend_q != PEND_MAX)) begin
            pend_d = pend_q + PEND_ONE;
        end else if (fw_valid && !fw_alloc && (pend_q != PEND_ZERO)) begin
            pend_d = pend_q - PEND_ONE;
        end

        flags_d = fw_valid ? flags_t'(fw_flags) : flags_q;
        hold_d  = accept ? in_br : hold_q;
        res_d   = res_q;
        state_d = state_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_no_wait) begin
                        res_d   = resolve(in_br, eval_flags);
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (hold_no_wait) begin
                    res_d   = resolve(hold_q, eval_flags);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                    if (accept) begin
                        if (in_no_wait) begin
                            res_d   = resolve(in_br, eval_flags);
                            state_d = RESP;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            flags_q <= '0;
            pend_q  <= '0;
            hold_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            res_q   <= res_d;
        end
    end

    assign res_valid      = state_q == RESP;
    assign res_taken      = res_q.taken;
    assign res_mispredict = res_q.mispredict;
    assign res_pc         = res_q.pc;
    assign res_tag        = res_q.tag;
    assign dbg_state      = state_q;
    assign dbg_pend       = pend_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: condition table, directed multi-cycle sequences and random
// traffic compared cycle by cycle against a behavioural model of the flags/branch rules.
module tb_branch_cond_unit;

    localparam int PEND_W = 3;
    localparam int TAG_W  = 4;
    localparam int PEND_MAX = (1 << PEND_W) - 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              fw_alloc;
    logic              fw_alloc_rdy;
    logic              fw_valid;
    logic [3:0]        fw_flags;
    logic              br_valid;
    logic              br_ready;
    logic [2:0]        br_cond;
    logic              br_pred_taken;
    logic [31:0]       br_target;
    logic [31:0]       br_fallthru;
    logic [TAG_W-1:0]  br_tag;
    logic              res_valid;
    logic              res_ready;
    logic              res_taken;
    logic              res_mispredict;
    logic [31:0]       res_pc;
    logic [TAG_W-1:0]  res_tag;
    logic [1:0]        dbg_state;
    logic [PEND_W-1:0] dbg_pend;

    branch_cond_unit #(.PEND_W(PEND_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fw_alloc(fw_alloc), .fw_alloc_rdy(fw_alloc_rdy),
        .fw_valid(fw_valid), .fw_flags(fw_flags),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
        .br_pred_taken(br_pred_taken), .br_target(br_target),
        .br_fallthru(br_fallthru), .br_tag(br_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_mispredict(res_mispredict), .res_pc(res_pc), .res_tag(res_tag),
        .dbg_state(dbg_state), .dbg_pend(dbg_pend)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // behavioural model: counters, a waiting-branch slot and an expected-result queue
    int          m_pend;
    logic [3:0]  m_flags;
    logic        m_wait;
    logic [2:0]  m_w_cond;
    logic        m_w_pred;
    logic [31:0] m_w_target, m_w_fallthru;
    logic [TAG_W-1:0] m_w_tag;
    logic [TAG_W+33:0] exp_q[$];   // {taken, mispredict, pc, tag}

    function automatic logic model_cond(input logic [2:0] code, input logic [3:0] f);
        logic v, c, s, z;
        {v, c, s, z} = f;
        case (code)
            3'd0: return z;
            3'd1: return !z;
            3'd2: return s != v;
            3'd3: return s == v;
            3'd4: return c;
            3'd5: return !c;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [TAG_W+33:0] model_res(input logic [2:0] code, input logic pred,
        input logic [31:0] tgt, input logic [31:0] ft, input logic [TAG_W-1:0] tag,
        input logic [3:0] f);
        logic t;
        t = model_cond(code, f);
        return {t, t ^ pred, t ? tgt : ft, tag};
    endfunction

    task automatic model_update(input logic rdy);
        logic       ready_now, last_done;
        logic [3:0] use_f;
        if (rst) begin
            m_pend = 0; m_flags = 4'h0; m_wait = 1'b0; exp_q.delete();
            return;
        end
        last_done = (m_pend == 1) && fw_valid && !fw_alloc;
        ready_now = (m_pend == 0) || last_done;
        use_f     = last_done ? fw_flags : m_flags;
        if (flush) begin
            m_wait = 1'b0; exp_q.delete(); m_pend = 0;
        end else begin
            if (exp_q.size() > 0 && res_ready) void'(exp_q.pop_front());
            if (m_wait && ready_now) begin
                exp_q.push_back(model_res(m_w_cond, m_w_pred, m_w_target, m_w_fallthru,
                                          m_w_tag, use_f));
                m_wait = 1'b0;
            end else if (br_valid && rdy) begin
                if (ready_now || br_cond >= 3'd6) begin
                    exp_q.push_back(model_res(br_cond, br_pred_taken, br_target, br_fallthru,
                                              br_tag, use_f));
                end else begin
                    m_wait = 1'b1; m_w_cond = br_cond; m_w_pred = br_pred_taken;
                    m_w_target = br_target; m_w_fallthru = br_fallthru; m_w_tag = br_tag;
                end
            end
            if (fw_alloc && !fw_valid && m_pend < PEND_MAX) m_pend++;
            else if (fw_valid && !fw_alloc && m_pend > 0) m_pend--;
        end
        if (fw_valid) m_flags = fw_flags;
    endtask

    // one clock: compare against the model, advance it at the edge, return at the negedge
    task automatic cyc();
        logic exp_rdy;
        logic [TAG_W+33:0] e;
        exp_rdy = !rst && !flush && !m_wait && (exp_q.size() == 0 || res_ready);
        #1;
        check("br_ready", 64'(br_ready), 64'(exp_rdy));
        check("fw_alloc_rdy", 64'(fw_alloc_rdy), 64'(m_pend != PEND_MAX));
        check("pend", 64'(dbg_pend), 64'(m_pend));
        check("res_valid", 64'(res_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("res_fields", {res_taken, res_mispredict, res_pc, res_tag}, 64'(e));
        end
        @(posedge clk);
        model_update(exp_rdy);
        @(negedge clk);
    endtask

    task automatic offer(input logic [2:0] code, input logic pred, input logic [31:0] tgt,
                         input logic [31:0] ft, input logic [TAG_W-1:0] tag);
        br_valid = 1'b1; br_cond = code; br_pred_taken = pred;
        br_target = tgt; br_fallthru = ft; br_tag = tag;
    endtask

    typedef struct {
        logic [2:0] cond;
        logic [3:0] flags;   // {v,c,s,z}
        logic       exp_taken;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{3'd0, 4'b0001, 1'b1};  vecs[1]  = '{3'd0, 4'b0000, 1'b0};
        vecs[2]  = '{3'd1, 4'b0001, 1'b0};  vecs[3]  = '{3'd1, 4'b1110, 1'b1};
        vecs[4]  = '{3'd2, 4'b1000, 1'b1};  vecs[5]  = '{3'd2, 4'b1010, 1'b0};
        vecs[6]  = '{3'd3, 4'b0010, 1'b0};  vecs[7]  = '{3'd3, 4'b0000, 1'b1};
        vecs[8]  = '{3'd4, 4'b0100, 1'b1};  vecs[9]  = '{3'd4, 4'b1011, 1'b0};
        vecs[10] = '{3'd5, 4'b0100, 1'b0};  vecs[11] = '{3'd5, 4'b0000, 1'b1};
        vecs[12] = '{3'd6, 4'b0000, 1'b1};  vecs[13] = '{3'd6, 4'b1111, 1'b1};
        vecs[14] = '{3'd7, 4'b1111, 1'b0};  vecs[15] = '{3'd7, 4'b0000, 1'b0};

        m_pend = 0; m_flags = 4'h0; m_wait = 1'b0;
        rst = 1'b1; flush = 1'b0; fw_alloc = 1'b0; fw_valid = 1'b0; fw_flags = 4'h0;
        br_valid = 1'b0; br_cond = 3'd0; br_pred_taken = 1'b0; br_target = 32'h0;
        br_fallthru = 32'h0; br_tag = '0; res_ready = 1'b0;

        // reset state
        @(negedge clk);
        br_valid = 1'b1;
        repeat (2) cyc();
        check("rst_br_ready", 64'(br_ready), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_fields", {res_taken, res_mispredict, res_pc, res_tag}, 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        br_valid = 1'b0;
        rst = 1'b0;
        cyc();

        // condition code table
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fw_valid = 1'b1; fw_flags = vecs[i].flags;
            cyc();
            fw_valid = 1'b0;
            offer(vecs[i].cond, i[0], 32'h1000 + i, 32'h2000 + i, TAG_W'(i));
            cyc();
            br_valid = 1'b0;
            check("tbl_valid", 64'(res_valid), 64'(1));
            check("tbl_taken", 64'(res_taken), 64'(vecs[i].exp_taken));
            check("tbl_mispredict", 64'(res_mispredict), 64'(vecs[i].exp_taken ^ i[0]));
            check("tbl_pc", 64'(res_pc), vecs[i].exp_taken ? 64'(32'h1000 + i) : 64'(32'h2000 + i));
        end
        cyc();

        // 1: writer, then branch in the writeback cycle uses the bypassed flags
        fw_alloc = 1'b1; cyc(); fw_alloc = 1'b0;
        fw_valid = 1'b1; fw_flags = 4'b0001;
        offer(3'd0, 1'b0, 32'h100, 32'h104, 4'd1);
        cyc();
        fw_valid = 1'b0; br_valid = 1'b0;
        check("t1_valid", 64'(res_valid), 64'(1));
        check("t1_res", {res_taken, res_mispredict, res_pc}, {1'b1, 1'b1, 32'h100});
        cyc();

        // 2: LT waits for its writer, resolves the cycle after writeback
        fw_alloc = 1'b1; cyc(); fw_alloc = 1'b0;
        offer(3'd2, 1'b0, 32'h200, 32'h204, 4'd2);
        cyc();
        br_valid = 1'b0; res_ready = 1'b0;
        check("t2_state_wait", 64'(dbg_state), 64'(1));
        check("t2_no_res", 64'(res_valid), 64'(0));
        repeat (2) cyc();
        check("t2_still_waiting", 64'(res_valid), 64'(0));
        fw_valid = 1'b1; fw_flags = 4'b1000;
        cyc();
        fw_valid = 1'b0;
        check("t2_res", {res_valid, res_taken, res_pc}, {1'b1, 1'b1, 32'h200});
        res_ready = 1'b1; cyc();

        // 3: ALWAYS ignores pending writers; result held until consumed
        fw_alloc = 1'b1; repeat (2) cyc(); fw_alloc = 1'b0;
        res_ready = 1'b0;
        offer(3'd6, 1'b1, 32'h300, 32'h304, 4'd5);
        cyc();
        offer(3'd6, 1'b1, 32'h400, 32'h404, 4'd6);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_br_ready_low", 64'(br_ready), 64'(0));
            check("t3_hold", {res_valid, res_pc, res_tag}, {1'b1, 32'h300, 4'd5});
            cyc();
        end
        res_ready = 1'b1;
        #1 check("t3_br_ready_on_ack", 64'(br_ready), 64'(1));
        cyc();
        br_valid = 1'b0;
        check("t3_second", {res_valid, res_tag}, {1'b1, 4'd6});
        cyc();
        fw_valid = 1'b1; repeat (2) cyc(); fw_valid = 1'b0;
        check("t3_drained", 64'(dbg_pend), 64'(0));

        // 4: saturate the writer counter
        fw_alloc = 1'b1; repeat (7) cyc();
        check("t4_rdy_low", 64'(fw_alloc_rdy), 64'(0));
        check("t4_pend7", 64'(dbg_pend), 64'(7));
        fw_valid = 1'b1; cyc();
        fw_alloc = 1'b0; fw_valid = 1'b0;
        check("t4_pend_kept", 64'(dbg_pend), 64'(7));

        // 5: flush drops a waiting GEU and the pending count
        offer(3'd5, 1'b0, 32'h500, 32'h504, 4'd9);
        cyc();
        br_valid = 1'b0;
        check("t5_wait", 64'(dbg_state), 64'(1));
        flush = 1'b1;
        #1 check("t5_flush_br_ready", 64'(br_ready), 64'(0));
        cyc();
        flush = 1'b0;
        check("t5_after_flush", {dbg_state, res_valid, dbg_pend}, {2'd0, 1'b0, 3'd0});
        offer(3'd5, 1'b0, 32'h600, 32'h604, 4'd10);
        #1 check("t5_accept_now", 64'(br_ready), 64'(1));
        cyc();
        br_valid = 1'b0;
        check("t5_res", {res_valid, res_tag}, {1'b1, 4'd10});
        cyc();

        // 6: back-to-back NE / LTU / NEVER
        fw_valid = 1'b1; fw_flags = 4'b0100; cyc(); fw_valid = 1'b0;
        offer(3'd1, 1'b1, 32'h700, 32'h704, 4'd1); cyc();
        check("t6_ne", {res_valid, res_taken, res_tag}, {1'b1, 1'b1, 4'd1});
        offer(3'd4, 1'b0, 32'h800, 32'h804, 4'd2); cyc();
        check("t6_ltu", {res_valid, res_taken, res_tag}, {1'b1, 1'b1, 4'd2});
        offer(3'd7, 1'b1, 32'h900, 32'h904, 4'd3); cyc();
        check("t6_never", {res_valid, res_taken, res_mispredict, res_tag}, {1'b1, 1'b0, 1'b1, 4'd3});
        br_valid = 1'b0; cyc();
        check("t6_empty", 64'(res_valid), 64'(0));

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 59) == 0);
            fw_alloc = (m_pend < PEND_MAX) && ($urandom_range(0, 2) == 0);
            fw_valid = ($urandom_range(0, 2) == 0);
            fw_flags = 4'($urandom_range(0, 15));
            offer(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  TAG_W'($urandom_range(0, 15)));
            br_valid  = ($urandom_range(0, 1) == 1);
            res_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
